// File: rtl/scalar_reg_file_p.sv
// Scalar register file with two registered read ports, one write port and a
// per-register busy scoreboard (reserve sets, write clears, reserve wins).
module scalar_reg_file_p #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic [DATA_W-1:0] data_1,
   output logic [DATA_W-1:0] data_2,
   output logic              busy_1,
   output logic              busy_2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_dst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_dst,
   output logic [ADDR_W:0]   busy_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam bit          ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [DEPTH-1:0]  wr_sel;
   logic [DEPTH-1:0]  rsv_sel;
   logic [CNT_W-1:0]  count_nxt;
   logic              wr_ok;
   logic              rsv_ok;
   logic              zero_1;
   logic              zero_2;
   logic [DATA_W-1:0] rd_val_1;
   logic [DATA_W-1:0] rd_val_2;
   logic              rd_busy_1;
   logic              rd_busy_2;

   // Hardwired-zero register swallows writes and reservations entirely.
   assign wr_ok  = wr_en  && !(ZERO_EN && (wr_dst  == '0));
   assign rsv_ok = rsv_en && !(ZERO_EN && (rsv_dst == '0));
   assign zero_1 = ZERO_EN && (rd_addr_1 == '0);
   assign zero_2 = ZERO_EN && (rd_addr_2 == '0);

   // One-hot write/reserve decode.
   always_comb begin
      wr_sel  = '0;
      rsv_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_sel[i]  = wr_ok  && (wr_dst  == ADDR_W'(i));
         rsv_sel[i] = rsv_ok && (rsv_dst == ADDR_W'(i));
      end
   end

   // Post-edge scoreboard: a same-edge reservation overrides the write clear.
   always_comb begin
      busy_nxt  = (busy & ~wr_sel) | rsv_sel;
      count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_nxt = count_nxt + CNT_W'(busy_nxt[i]);
      end
   end

   // Read values including write-through bypass and post-edge busy.
   always_comb begin
      rd_val_1  = regs[rd_addr_1];
      rd_val_2  = regs[rd_addr_2];
      if (wr_ok && (wr_dst == rd_addr_1)) rd_val_1 = wr_data;
      if (wr_ok && (wr_dst == rd_addr_2)) rd_val_2 = wr_data;
      rd_busy_1 = busy_nxt[rd_addr_1];
      rd_busy_2 = busy_nxt[rd_addr_2];
      if (zero_1) begin
         rd_val_1  = '0;
         rd_busy_1 = 1'b0;
      end
      if (zero_2) begin
         rd_val_2  = '0;
         rd_busy_2 = 1'b0;
      end
   end

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) regs[i] <= wr_data;
         end
      end
   end

   // Scoreboard and its population count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

   // Read port registers; hold while rd_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_1 <= '0;
         data_2 <= '0;
         busy_1 <= 1'b0;
         busy_2 <= 1'b0;
      end else if (rd_en) begin
         data_1 <= rd_val_1;
         data_2 <= rd_val_2;
         busy_1 <= rd_busy_1;
         busy_2 <= rd_busy_2;
      end
   end

endmodule
